// File: rtl/dut_fifo_channel_if.sv
// Data channel bundle between a word source (rxd/rx_dv), the FIFO channel and
// a word sink (txd/tx_en/tx_ready).
//
// Handshake semantics (both sides):
//   - Input side: one word is offered on every rising edge where rx_dv=1.
//     There is no back-pressure toward the source. The channel takes the word
//     if it has room and drops it otherwise.
//   - Output side: txd is valid while tx_en=1. A word moves to the sink on a
//     rising edge where tx_en=1 and tx_ready=1. While tx_en=1 and tx_ready=0,
//     txd and tx_en stay unchanged. tx_en is never withdrawn before a transfer.
//
// Ports:
//   rxd, rx_dv       source -> channel
//   txd, tx_en       channel -> sink
//   tx_ready         sink -> channel
// Modports:
//   master  used by the bench/environment (drives rxd, rx_dv and tx_ready)
//   slave   used by the channel itself
interface dut_fifo_channel_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rxd;
  logic              rx_dv;
  logic [DATA_W-1:0] txd;
  logic              tx_en;
  logic              tx_ready;

  modport master (
    output rxd,
    output rx_dv,
    output tx_ready,
    input  txd,
    input  tx_en
  );

  modport slave (
    input  rxd,
    input  rx_dv,
    input  tx_ready,
    output txd,
    output tx_en
  );
endinterface

// File: rtl/dut_fifo_channel.sv
// DEPTH-word FIFO data channel. An output register drives txd/tx_en, and
// DEPTH-1 storage entries sit behind it. Words offered while the channel is
// full are dropped. Drops set a sticky ovf flag and are counted in a
// saturating drop_cnt.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   ch         channel interface (slave): rxd/rx_dv in, txd/tx_en out, tx_ready in
//   level      words held, output register included (0..DEPTH)
//   full       level == DEPTH
//   ovf        sticky: at least one word was dropped
//   ovf_clr    synchronous clear of ovf and drop_cnt (wins over a same-cycle drop)
//   drop_cnt   saturating count of dropped words
module dut_fifo_channel #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  dut_fifo_channel_if.slave ch,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] drop_cnt
);

  // Storage behind the output register.
  localparam int SW  = DEPTH - 1;
  localparam int PW  = (SW > 1) ? $clog2(SW) : 1;
  localparam int SCW = $clog2(SW + 1);

  logic [DATA_W-1:0] mem [SW];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [SCW-1:0]    scnt;

  logic [DATA_W-1:0] txd_q;
  logic              tx_en_q;

  logic wr;
  logic drop;
  logic pop;
  logic out_load;
  logic stor_pop;
  logic bypass;
  logic stor_push;

  assign ch.txd   = txd_q;
  assign ch.tx_en = tx_en_q;

  // full comes from the registered level. A pop on the same edge therefore
  // never makes room for a write in that cycle.
  assign full = (level == LW'(DEPTH));

  assign wr   = ch.rx_dv & ~full;
  assign drop = ch.rx_dv & full;
  assign pop  = tx_en_q & ch.tx_ready;

  // The output register reloads when it is empty or being popped. It takes
  // the storage head first, and takes rxd directly only when storage is empty.
  // This bypass gives the one-cycle latency through an empty channel.
  assign out_load  = ~tx_en_q | pop;
  assign stor_pop  = out_load & (scnt != '0);
  assign bypass    = out_load & (scnt == '0) & wr;
  assign stor_push = wr & ~bypass;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(SW - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Storage array holds data only. Pointers and count decide what is live, so
  // no reset is needed here.
  always_ff @(posedge clk) begin
    if (stor_push) mem[wr_ptr] <= ch.rxd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd_q    <= '0;
      tx_en_q  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      scnt     <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      // txd keeps its last value when the channel drains. Only tx_en falls.
      if (out_load) begin
        if (stor_pop) begin
          txd_q   <= mem[rd_ptr];
          tx_en_q <= 1'b1;
        end else if (bypass) begin
          txd_q   <= ch.rxd;
          tx_en_q <= 1'b1;
        end else begin
          tx_en_q <= 1'b0;
        end
      end

      if (stor_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (stor_push) wr_ptr <= ptr_inc(wr_ptr);

      case ({stor_push, stor_pop})
        2'b10:   scnt <= scnt + 1'b1;
        2'b01:   scnt <= scnt - 1'b1;
        default: scnt <= scnt;
      endcase

      case ({wr, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (ovf_clr) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dut_fifo_channel.sv
// Bench for dut_fifo_channel (DEPTH=4, CNT_W=2 so that saturation is reachable).
// A queue-based model predicts every output after each edge. Directed scenarios
// add literal expectations, and a short random phase follows.
module tb_dut_fifo_channel;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int CMAX   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             ovf_clr = 1'b0;
  logic [LW-1:0]    level;
  logic             full;
  logic             ovf;
  logic [CNT_W-1:0] drop_cnt;

  dut_fifo_channel_if #(.DATA_W(DATA_W)) ch ();

  dut_fifo_channel #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ch       (ch),
    .level    (level),
    .full     (full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds every word the channel holds. Its head is what txd must show.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_txd = '0;
  bit                m_ovf = 1'b0;
  int                m_cnt = 0;
  bit                m_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_txd = '0;
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      m_full = (exp_q.size() == DEPTH);
      if (ovf_clr) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end else if (ch.rx_dv && m_full) begin
        m_ovf = 1'b1;
        if (m_cnt < CMAX) m_cnt++;
      end
      if (exp_q.size() > 0 && ch.tx_ready) void'(exp_q.pop_front());
      if (ch.rx_dv && !m_full) exp_q.push_back(ch.rxd);
      if (exp_q.size() > 0) m_txd = exp_q[0];
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(posedge clk) begin
    #1;
    if (started && !rst) begin
      check("sb_tx_en", 32'(ch.tx_en), 32'(exp_q.size() > 0));
      check("sb_txd", 32'(ch.txd), 32'(m_txd));
      check("sb_level", 32'(level), 32'(exp_q.size()));
      check("sb_full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("sb_ovf", 32'(ovf), 32'(m_ovf));
      check("sb_drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    end
  end

  // ---------------- driver ----------------
  // Inputs change just after a falling edge and are consumed by the next
  // rising edge. The task returns at the following falling edge.
  task automatic step(input logic dv, input logic [DATA_W-1:0] d,
                      input logic rdy, input logic clr);
    ch.rx_dv    = dv;
    ch.rxd      = d;
    ch.tx_ready = rdy;
    ovf_clr     = clr;
    @(negedge clk);
  endtask

  logic [DATA_W-1:0] a_seq [4];
  logic [DATA_W-1:0] c_seq [4];

  initial begin
    ch.rx_dv    = 1'b0;
    ch.rxd      = '0;
    ch.tx_ready = 1'b0;
    #3;
    check("rst_txd", 32'(ch.txd), 32'h0);
    check("rst_tx_en", 32'(ch.tx_en), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    started = 1'b1;

    // 1. passthrough with one-cycle latency
    step(1'b1, 8'h11, 1'b1, 1'b0);
    check("t1_txd0", 32'(ch.txd), 32'h11);
    check("t1_en0", 32'(ch.tx_en), 32'h1);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    check("t1_txd1", 32'(ch.txd), 32'h22);
    check("t1_lvl1", 32'(level), 32'h1);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    check("t1_txd2", 32'(ch.txd), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_empty", 32'(ch.tx_en), 32'h0);
    check("t1_txd_hold", 32'(ch.txd), 32'h33);
    check("t1_ovf", 32'(ovf), 32'h0);

    // 2. backpressure fill and drops
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      if (i == 3) check("t2_full", 32'(full), 32'h1);
    end
    check("t2_drop_cnt", 32'(drop_cnt), 32'h2);
    check("t2_ovf", 32'(ovf), 32'h1);
    check("t2_head", 32'(ch.txd), 32'hA0);
    a_seq = '{8'hA1, 8'hA2, 8'hA3, 8'h00};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (i < 3) check("t2_drain", 32'(ch.txd), 32'(a_seq[i]));
    end
    check("t2_done", 32'(ch.tx_en), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t2_clr", 32'(ovf), 32'h0);

    // 3. stall stability
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    step(1'b1, 8'h5D, 1'b0, 1'b0);
    check("t3_lvl", 32'(level), 32'h2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("t3_hold_txd", 32'(ch.txd), 32'h5C);
      check("t3_hold_en", 32'(ch.tx_en), 32'h1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_pop_lvl", 32'(level), 32'h1);
    check("t3_next", 32'(ch.txd), 32'h5D);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 4. full with simultaneous pop and write
    for (int i = 0; i < 4; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("t4_lvl", 32'(level), 32'(DEPTH - 1));
    check("t4_drop", 32'(drop_cnt), 32'h1);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("t4_accept", 32'(level), 32'(DEPTH));
    c_seq = '{8'h72, 8'h73, 8'h77, 8'h77};
    check("t4_head", 32'(ch.txd), 32'h71);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (i < 3) check("t4_order", 32'(ch.txd), 32'(c_seq[i]));
    end
    check("t4_empty", 32'(ch.tx_en), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // 5. saturation and clear-wins
    for (int i = 0; i < 4; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'hF0 + 8'(i), 1'b0, 1'b0);
    check("t5_sat", 32'(drop_cnt), 32'(CMAX));
    check("t5_ovf", 32'(ovf), 32'h1);
    step(1'b1, 8'hF5, 1'b0, 1'b1);
    check("t5_clr_cnt", 32'(drop_cnt), 32'h0);
    check("t5_clr_ovf", 32'(ovf), 32'h0);

    // 6. async reset mid-stream
    step(1'b1, 8'hF6, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_pre_lvl", 32'(level), 32'h3);
    check("t6_pre_ovf", 32'(ovf), 32'h1);
    ch.tx_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_en", 32'(ch.tx_en), 32'h0);
    check("t6_rst_lvl", 32'(level), 32'h0);
    check("t6_rst_ovf", 32'(ovf), 32'h0);
    check("t6_rst_cnt", 32'(drop_cnt), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    check("t6_txd", 32'(ch.txd), 32'h99);
    check("t6_lvl", 32'(level), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_no_stale", 32'(ch.tx_en), 32'h0);

    // mixed random traffic, scoreboard only (exercises pointer wrap)
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("final_empty", 32'(level), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
